// File: rtl/unstack_controller_if.sv
// Pop-sequencer bundle: trigger/SP inputs, data-memory read port, and redirect/restore strobes.
// stack_err exists only when UNSTACK_UNDERFLOW_CHECK_EN is defined.
interface unstack_controller_if #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int FLAGS_W = 3
);
    logic                  pop_pc;
    logic                  pop_flags;
    logic [ADDR_W-1:0]     sp_in;
    logic [DATA_W-1:0]     mem_rd_data;
    logic                  mem_rd;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  stall;
    logic                  flags_load;
    logic [FLAGS_W-1:0]    flags_out;
    logic                  pc_load;
    logic [2*DATA_W-1:0]   pc_out;
    logic                  sp_wr_en;
    logic [ADDR_W-1:0]     sp_out;
    logic                  busy;
`ifdef UNSTACK_UNDERFLOW_CHECK_EN
    logic                  stack_err;
`endif

    modport master (
        input  pop_pc, pop_flags, sp_in, mem_rd_data,
`ifdef UNSTACK_UNDERFLOW_CHECK_EN
        output stack_err,
`endif
        output mem_rd, mem_addr, stall, flags_load, flags_out,
               pc_load, pc_out, sp_wr_en, sp_out, busy
    );

    modport slave (
        output pop_pc, pop_flags, sp_in, mem_rd_data,
`ifdef UNSTACK_UNDERFLOW_CHECK_EN
        input  stack_err,
`endif
        input  mem_rd, mem_addr, stall, flags_load, flags_out,
               pc_load, pc_out, sp_wr_en, sp_out, busy
    );
endinterface

// File: rtl/unstack_controller.sv
// Purpose: RET/RTI pop sequencer (flags, PC low, PC high), restores flags, redirects PC, updates SP.
// Latency: pc_load 3 cycles after the trigger edge for RET, 4 for RTI; optional UNSTACK_UNDERFLOW_CHECK_EN.
// Backpressure: none accepted; stalls IF/ID/EX while reading, ignores pop_* until back in IDLE.
module unstack_controller #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int FLAGS_W = 3
`ifdef UNSTACK_UNDERFLOW_CHECK_EN
    ,
    parameter int unsigned STACK_TOP = 2**ADDR_W - 1
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    unstack_controller_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_FLAGS = 3'd1,
        RD_LO    = 3'd2,
        RD_HI    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   base_sp;
    logic                is_rti;
    logic [DATA_W-1:0]   pc_lo_reg;
    logic                trigger;
    logic                accept;

    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic                stall;
    logic                flags_load;
    logic [FLAGS_W-1:0]  flags_out;
    logic                pc_load;
    logic [2*DATA_W-1:0] pc_out;
    logic                sp_wr_en;
    logic [ADDR_W-1:0]   sp_out;

    // Slot offsets relative to base_sp; F shifts the PC words up by one for RTI.
    logic [ADDR_W-1:0]   addr_first;
    logic [ADDR_W-1:0]   addr_lo;
    logic [ADDR_W-1:0]   addr_hi;

    assign trigger    = (state == IDLE) && bus.pop_pc;
    assign addr_first = base_sp + ADDR_W'(1);
    assign addr_lo    = addr_first + ADDR_W'(is_rti);
    assign addr_hi    = addr_lo + ADDR_W'(1);

`ifdef UNSTACK_UNDERFLOW_CHECK_EN
    logic                underflow;
    logic                stack_err_q;
    logic [ADDR_W:0]     sp_need;

    // One extra bit so sp_in+2+F cannot wrap before the comparison.
    assign sp_need   = {1'b0, bus.sp_in} + (ADDR_W+1)'(bus.pop_flags ? 3 : 2);
    assign underflow = sp_need > (ADDR_W+1)'(STACK_TOP);
    assign accept    = trigger && !underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            stack_err_q <= 1'b0;
        end else begin
            stack_err_q <= trigger && underflow;
        end
    end

    assign bus.stack_err = stack_err_q;
`else
    assign accept = trigger;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_sp   <= '0;
            is_rti    <= 1'b0;
            pc_lo_reg <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                base_sp <= bus.sp_in;
                is_rti  <= bus.pop_flags;
            end
            if (state == RD_HI) begin
                pc_lo_reg <= bus.mem_rd_data;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        stall      = 1'b0;
        flags_load = 1'b0;
        flags_out  = '0;
        pc_load    = 1'b0;
        pc_out     = '0;
        sp_wr_en   = 1'b0;
        sp_out     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = bus.pop_flags ? RD_FLAGS : RD_LO;
                end
            end
            RD_FLAGS: begin
                mem_rd    = 1'b1;
                mem_addr  = addr_first;
                stall     = 1'b1;
                state_nxt = RD_LO;
            end
            RD_LO: begin
                mem_rd   = 1'b1;
                mem_addr = addr_lo;
                stall    = 1'b1;
                // Read data here is the flags word fetched in RD_FLAGS.
                if (is_rti) begin
                    flags_load = 1'b1;
                    flags_out  = bus.mem_rd_data[FLAGS_W-1:0];
                end
                state_nxt = RD_HI;
            end
            RD_HI: begin
                mem_rd    = 1'b1;
                mem_addr  = addr_hi;
                stall     = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                pc_load   = 1'b1;
                pc_out    = {bus.mem_rd_data, pc_lo_reg};
                sp_wr_en  = 1'b1;
                sp_out    = addr_hi;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_rd     = mem_rd;
    assign bus.mem_addr   = mem_addr;
    assign bus.stall      = stall;
    assign bus.flags_load = flags_load;
    assign bus.flags_out  = flags_out;
    assign bus.pc_load    = pc_load;
    assign bus.pc_out     = pc_out;
    assign bus.sp_wr_en   = sp_wr_en;
    assign bus.sp_out     = sp_out;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_unstack_controller.sv
// Randomized bench for unstack_controller: stack-slot reference model, directed RET/RTI/retrigger/reset/wrap cases.
// Build with +define+UNSTACK_UNDERFLOW_CHECK_EN to exercise stack_err.
module tb_unstack_controller;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 16;
    localparam int FLAGS_W = 3;
    localparam int DEPTH   = 2**ADDR_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    unstack_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FLAGS_W(FLAGS_W)) bus ();

    unstack_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FLAGS_W(FLAGS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Data memory: read data one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rd_data <= mem[bus.mem_addr];
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-sequence observations, one entry per cycle after the trigger edge.
    logic [ADDR_W-1:0]   addr_q[$];
    int                  pcl_ks[$];
    int                  stall_n, fl_n, spw_n, spw_k, err_n, err_k;
    logic [FLAGS_W-1:0]  fl_val;
    logic [2*DATA_W-1:0] pc_val;
    logic [ADDR_W-1:0]   sp_val;
    logic                last_busy;

    task automatic run(input logic [ADDR_W-1:0] sp, input bit rti, input bit hold,
                       input int rst_k, input int n);
        @(negedge clk);
        bus.pop_pc    = 1'b1;
        bus.pop_flags = rti;
        bus.sp_in     = sp;
        addr_q.delete();
        pcl_ks.delete();
        stall_n = 0; fl_n = 0; spw_n = 0; spw_k = 0; err_n = 0; err_k = 0;
        fl_val = '0; pc_val = '0; sp_val = '0; last_busy = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (bus.mem_rd) addr_q.push_back(bus.mem_addr);
            stall_n += int'(bus.stall);
            if (bus.flags_load) begin fl_n++; fl_val = bus.flags_out; end
            if (bus.pc_load) begin pcl_ks.push_back(k); pc_val = bus.pc_out; end
            if (bus.sp_wr_en) begin spw_n++; spw_k = k; sp_val = bus.sp_out; end
`ifdef UNSTACK_UNDERFLOW_CHECK_EN
            if (bus.stack_err) begin err_n++; err_k = k; end
`endif
            last_busy = bus.busy;
            if (!hold || k == n) begin
                bus.pop_pc    = 1'b0;
                bus.pop_flags = 1'($urandom);
                bus.sp_in     = ADDR_W'($urandom);
            end
            rst = (k == rst_k);
        end
        bus.pop_flags = 1'b0;
    endtask

    // Reference: the top item is at sp+1; RTI takes flags first, then PC low and PC high above it.
    task automatic check_pop(input logic [ADDR_W-1:0] sp, input bit rti);
        int f = int'(rti);
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] lo_a;
        logic [ADDR_W-1:0] hi_a;
        lo_a = sp + ADDR_W'(1 + f);
        hi_a = sp + ADDR_W'(2 + f);
`ifdef UNSTACK_UNDERFLOW_CHECK_EN
        if (int'(sp) + 2 + f > DEPTH - 1) begin
            chk("uf_err_n", 64'(err_n), 64'd1);
            chk("uf_err_k", 64'(err_k), 64'd1);
            chk("uf_reads", 64'(addr_q.size()), 64'd0);
            chk("uf_stall", 64'(stall_n), 64'd0);
            chk("uf_pcload", 64'(pcl_ks.size()), 64'd0);
            chk("uf_spwr", 64'(spw_n), 64'd0);
            chk("uf_flload", 64'(fl_n), 64'd0);
            return;
        end
        chk("err_n", 64'(err_n), 64'd0);
`endif
        chk("n_reads", 64'(addr_q.size()), 64'(2 + f));
        for (int i = 0; i < 2 + f && i < addr_q.size(); i++) begin
            a = sp + ADDR_W'(1 + i);
            chk("rd_addr", 64'(addr_q[i]), 64'(a));
        end
        chk("stall_cycles", 64'(stall_n), 64'(2 + f));
        chk("flags_loads", 64'(fl_n), 64'(f));
        if (rti) chk("flags_val", 64'(fl_val), 64'(mem[sp + ADDR_W'(1)][FLAGS_W-1:0]));
        chk("pc_loads", 64'(pcl_ks.size()), 64'd1);
        if (pcl_ks.size() > 0) chk("pc_latency", 64'(pcl_ks[0]), 64'(3 + f));
        chk("pc_val", 64'(pc_val), 64'({mem[hi_a], mem[lo_a]}));
        chk("sp_writes", 64'(spw_n), 64'd1);
        chk("sp_latency", 64'(spw_k), 64'(3 + f));
        chk("sp_val", 64'(sp_val), 64'(hi_a));
        chk("idle_after", 64'(last_busy), 64'd0);
    endtask

    function automatic logic [63:0] out_bits();
        logic [63:0] v;
        v = {bus.busy, bus.stall, bus.mem_rd, bus.pc_load, bus.sp_wr_en, bus.flags_load,
             bus.flags_out, bus.mem_addr, bus.sp_out} | 64'(bus.pc_out != '0);
`ifdef UNSTACK_UNDERFLOW_CHECK_EN
        v = v | 64'(bus.stack_err);
`endif
        return v;
    endfunction

    initial begin
        logic [ADDR_W-1:0] sp;
        bit rti;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        rst = 1'b1;
        bus.pop_pc = 1'b0;
        bus.pop_flags = 1'b0;
        bus.sp_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_bits(), 64'd0);
        rst = 1'b0;

        // pop_flags alone must not start anything.
        bus.pop_flags = 1'b1;
        bus.sp_in = 12'h100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flags_only_idle", out_bits(), 64'd0);
        end
        bus.pop_flags = 1'b0;

        // Directed RET.
        mem[12'hFFD] = 16'h1234;
        mem[12'hFFE] = 16'hABCD;
        run(12'hFFC, 1'b0, 1'b0, 0, 6);
        check_pop(12'hFFC, 1'b0);
        chk("ret_pc_const", 64'(pc_val), 64'hABCD1234);
        chk("ret_sp_const", 64'(sp_val), 64'hFFE);

        // Directed RTI.
        mem[12'hFFC] = 16'h0005;
        mem[12'hFFD] = 16'h0010;
        mem[12'hFFE] = 16'h0000;
        run(12'hFFB, 1'b1, 1'b0, 0, 6);
        check_pop(12'hFFB, 1'b1);
        chk("rti_flags_const", 64'(fl_val), 64'b101);
        chk("rti_pc_const", 64'(pc_val), 64'h00000010);

        // pop_pc held through a RET: retrigger only in the IDLE cycle after DONE.
        run(12'h200, 1'b0, 1'b1, 0, 8);
        chk("hold_pc_loads", 64'(pcl_ks.size()), 64'd2);
        if (pcl_ks.size() == 2) begin
            chk("hold_first_k", 64'(pcl_ks[0]), 64'd3);
            chk("hold_second_k", 64'(pcl_ks[1]), 64'd7);
        end
        chk("hold_idle_end", 64'(last_busy), 64'd0);

        // Reset while in RD_HI.
        run(12'h300, 1'b0, 1'b0, 2, 6);
        chk("rst_pc_loads", 64'(pcl_ks.size()), 64'd0);
        chk("rst_sp_writes", 64'(spw_n), 64'd0);
        chk("rst_stall", 64'(stall_n), 64'd2);
        chk("rst_idle", 64'(last_busy), 64'd0);

        // RTI near the top: underflow with the check, silent wrap without.
        run(12'hFFD, 1'b1, 1'b0, 0, 6);
        check_pop(12'hFFD, 1'b1);
`ifndef UNSTACK_UNDERFLOW_CHECK_EN
        chk("wrap_sp_const", 64'(sp_val), 64'h000);
`endif

        for (int t = 0; t < 60; t++) begin
            sp  = ($urandom_range(0, 3) == 0) ? ADDR_W'(12'hFF8 + $urandom_range(0, 7))
                                              : ADDR_W'($urandom);
            rti = 1'($urandom);
            for (int j = 0; j < 3; j++) mem[sp + ADDR_W'(1 + j)] = DATA_W'($urandom);
            run(sp, rti, 1'b0, 0, 6);
            check_pop(sp, rti);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
